edulent_control_unit: RTL

Microcoded control FSM for the Edulent 8-bit CPU. It reads the instruction register from the data path and drives the data path's one-command-per-cycle interface: transfer command, PC increment, SP increment/decrement, ALU strobe, ALU destination select and IR clear. It sequences fetch, decode and execute for every instruction, stops on HALT, and flags illegal opcodes.

---
 rtl/edulent_control_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/edulent_control_unit.sv
// Microcoded control FSM for the Edulent 8-bit CPU: fetch, decode and a
// per-opcode EXEC step sequence driving the data path one command per cycle.
module edulent_control_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_IR,
  output logic [3:0] o_transfer_cmd,
  output logic       o_inc_pc,
  output logic [1:0] o_inc_dec_sp,
  output logic       o_alu_calculate,
  output logic       o_alu_res_to_ap,
  output logic       o_reset_ir,
  output logic       o_halted,
  output logic       o_illegal
);

  typedef enum logic [2:0] {
    FETCH0, FETCH1, FETCH2, DECODE, EXEC, HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP, CL_LD_IMM, CL_LD_ABS, CL_LD_IND, CL_POP, CL_STA, CL_PUSH,
    CL_ALU_IMM, CL_ALU_UN, CL_JMP, CL_IN, CL_OUT, CL_JMP_AP, CL_HALT, CL_ILL
  } cls_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;

  cls_e       cls;
  logic [2:0] last_step;
  logic       has_op;
  logic [3:0] ex_cmd;
  logic       ex_pc;
  logic [1:0] ex_sp;
  logic       ex_alu;

  // Opcode classification; IR is stable through DECODE and EXEC.
  always_comb begin
    cls = CL_ILL;
    case (i_IR)
      8'h00:                cls = CL_NOP;
      8'h11, 8'h13:         cls = CL_LD_IMM;
      8'h19, 8'h1B:         cls = CL_LD_ABS;
      8'h14, 8'h1C:         cls = CL_LD_IND;
      8'h1E:                cls = CL_POP;
      8'h21, 8'h23:         cls = CL_STA;
      8'h2C, 8'h2E:         cls = CL_PUSH;
      8'hA1, 8'hA5, 8'hA9:  cls = CL_JMP;
      8'hB0:                cls = CL_IN;
      8'hB1:                cls = CL_OUT;
      8'hC0:                cls = CL_JMP_AP;
      8'hFF:                cls = CL_HALT;
      default: begin
        case (i_IR[7:4])
          4'h3, 4'h6, 4'h7, 4'h8: cls = CL_ALU_IMM;
          4'h5, 4'h9:             cls = CL_ALU_UN;
          default:                cls = CL_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    last_step = 3'd0;
    case (cls)
      CL_LD_IMM:  last_step = 3'd2;
      CL_LD_ABS:  last_step = 3'd4;
      CL_LD_IND:  last_step = 3'd2;
      CL_POP:     last_step = 3'd3;
      CL_STA:     last_step = 3'd4;
      CL_PUSH:    last_step = 3'd2;
      CL_ALU_IMM: last_step = 3'd3;
      CL_ALU_UN:  last_step = 3'd1;
      CL_JMP:     last_step = 3'd2;
      default:    last_step = 3'd0;
    endcase
  end

  assign has_op = (cls == CL_LD_IMM) || (cls == CL_LD_ABS) || (cls == CL_STA) ||
                  (cls == CL_ALU_IMM) || (cls == CL_JMP);

  // EXEC microcode: steps 0/1 are the shared operand fetch where present.
  always_comb begin
    ex_cmd = 4'h0;
    ex_pc  = 1'b0;
    ex_sp  = 2'b00;
    ex_alu = 1'b0;
    if (has_op && step_q == 3'd0) ex_cmd = 4'h1;
    if (has_op && step_q == 3'd1) begin
      ex_cmd = 4'h2;
      ex_pc  = 1'b1;
    end
    case (cls)
      CL_LD_IMM: if (step_q == 3'd2) ex_cmd = 4'h5;
      CL_LD_ABS: begin
        case (step_q)
          3'd2:    ex_cmd = 4'h4;
          3'd3:    ex_cmd = 4'h2;
          3'd4:    ex_cmd = 4'h5;
          default: ;
        endcase
      end
      CL_LD_IND: begin
        case (step_q)
          3'd0:    ex_cmd = 4'h6;
          3'd1:    ex_cmd = 4'h2;
          3'd2:    ex_cmd = 4'h5;
          default: ;
        endcase
      end
      CL_POP: begin
        case (step_q)
          3'd0:    ex_sp  = 2'b01;
          3'd1:    ex_cmd = 4'h7;
          3'd2:    ex_cmd = 4'h2;
          3'd3:    ex_cmd = 4'h5;
          default: ;
        endcase
      end
      CL_STA: begin
        case (step_q)
          3'd2:    ex_cmd = 4'h4;
          3'd3:    ex_cmd = 4'h8;
          3'd4:    ex_cmd = 4'h9;
          default: ;
        endcase
      end
      CL_PUSH: begin
        case (step_q)
          3'd0:    ex_cmd = 4'h7;
          3'd1:    ex_cmd = 4'h8;
          3'd2: begin
            ex_cmd = 4'h9;
            ex_sp  = 2'b10;
          end
          default: ;
        endcase
      end
      CL_ALU_IMM: begin
        if (step_q == 3'd2) ex_alu = 1'b1;
        if (step_q == 3'd3) ex_cmd = 4'hA;
      end
      CL_ALU_UN: begin
        if (step_q == 3'd0) ex_alu = 1'b1;
        if (step_q == 3'd1) ex_cmd = 4'hA;
      end
      CL_JMP:    if (step_q == 3'd2) ex_cmd = 4'hB;
      CL_IN:     ex_cmd = 4'hC;
      CL_OUT:    ex_cmd = 4'hD;
      CL_JMP_AP: ex_cmd = 4'hE;
      default:   ;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    o_transfer_cmd  = 4'h0;
    o_inc_pc        = 1'b0;
    o_inc_dec_sp    = 2'b00;
    o_alu_calculate = 1'b0;
    o_alu_res_to_ap = 1'b0;
    o_reset_ir      = 1'b0;
    o_illegal       = 1'b0;
    o_halted        = (state_q == HALT);
    if (i_en) begin
      case (state_q)
        FETCH0: begin
          o_transfer_cmd = 4'h1;
          state_d        = FETCH1;
        end
        FETCH1: begin
          o_transfer_cmd = 4'h2;
          o_inc_pc       = 1'b1;
          state_d        = FETCH2;
        end
        FETCH2: begin
          o_transfer_cmd = 4'h3;
          state_d        = DECODE;
        end
        DECODE: begin
          step_d = 3'd0;
          case (cls)
            CL_NOP: begin
              o_reset_ir = 1'b1;
              state_d    = FETCH0;
            end
            CL_ILL: begin
              o_illegal  = 1'b1;
              o_reset_ir = 1'b1;
              state_d    = FETCH0;
            end
            CL_HALT: state_d = HALT;
            default: state_d = EXEC;
          endcase
        end
        EXEC: begin
          o_transfer_cmd  = ex_cmd;
          o_inc_pc        = ex_pc;
          o_inc_dec_sp    = ex_sp;
          o_alu_calculate = ex_alu;
          o_alu_res_to_ap = (i_IR[7:4] == 4'h3) && i_IR[3];
          if (step_q == last_step) begin
            o_reset_ir = 1'b1;
            step_d     = 3'd0;
            state_d    = FETCH0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        HALT:    ;
        default: state_d = FETCH0;
      endcase
    end
    // Reset wins over everything: no command may leak while it is held.
    if (i_rst) begin
      o_transfer_cmd  = 4'h0;
      o_inc_pc        = 1'b0;
      o_inc_dec_sp    = 2'b00;
      o_alu_calculate = 1'b0;
      o_alu_res_to_ap = 1'b0;
      o_reset_ir      = 1'b0;
      o_illegal       = 1'b0;
      o_halted        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH0;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

endmodule
